// File: rtl/control_sequencer.sv
// control_sequencer: parametrised T-state instruction sequencer.
// Steps a T-state counter, latches the opcode on the fetch edge and emits one
// microstate code per cycle. It adds four things: a memory-ready stall, a
// resumable halt, an illegal-opcode pulse and a runaway-step watchdog.
// Optional feature: define SINGLE_STEP_EN to add the step_req input. When it is
// defined, every instruction parks in STEP_WAIT after NEXT until step_req is seen.
module control_sequencer #(
    parameter int INSTR_W   = 8,
    parameter int OPC_W     = 4,
    parameter int STATE_W   = 8,
    parameter int MAX_STEPS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INSTR_W-1:0]           instruction,
    input  logic                         mem_ready,
    input  logic                         resume,
`ifdef SINGLE_STEP_EN
    input  logic                         step_req,
`endif
    output logic [STATE_W-1:0]           state,
    output logic [$clog2(MAX_STEPS)-1:0] cycle,
    output logic [OPC_W-1:0]             opcode,
    output logic                         halted,
    output logic                         illegal
);

    localparam int CW = $clog2(MAX_STEPS);

    typedef enum logic [3:0] {
        S_FETCH_PC   = 4'd0,
        S_FETCH_INST = 4'd1,
        S_NEXT       = 4'd2,
        S_HALT       = 4'd3,
        S_ALU_EXEC   = 4'd4,
        S_ALU_STORE  = 4'd5,
        S_JUMP       = 4'd6,
        S_SET_REG    = 4'd7,
        S_MOV_FETCH  = 4'd8,
        S_MOV_LOAD   = 4'd9,
        S_MOV_STORE  = 4'd10,
        S_STEP_WAIT  = 4'd11
    } state_t;

    localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ALU = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_MOV = OPC_W'(5);

    localparam logic [CW-1:0] LAST_STEP = CW'(MAX_STEPS - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cycle;
    logic [OPC_W-1:0]   r_opcode;
    logic               r_halted;
    logic               r_illegal;

    state_t             w_state_nxt;
    logic [CW-1:0]      w_cycle_nxt;
    logic [CW-1:0]      w_cycle_inc;
    logic [OPC_W-1:0]   w_opc_in;
    logic [OPC_W-1:0]   w_opc_eff;
    logic               w_latch;
    logic               w_illegal_nxt;
    logic               w_unused_instr;

    // Only the opcode field of the instruction is decoded; the operand bits
    // belong to the datapath.
    assign w_opc_in       = instruction[INSTR_W-1 -: OPC_W];
    assign w_unused_instr = ^instruction;
    assign w_cycle_inc    = r_cycle + 1'b1;

    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        return (opc == OP_NOP) || (opc == OP_HLT) || (opc == OP_ALU) ||
               (opc == OP_JMP) || (opc == OP_LDI) || (opc == OP_MOV);
    endfunction

    // Next-state, next-cycle and opcode-capture decision for the current T-state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cycle_nxt   = r_cycle;
        w_opc_eff     = r_opcode;
        w_latch       = 1'b0;
        w_illegal_nxt = 1'b0;

        case (r_state)
            S_FETCH_PC: begin
                // The first FETCH_PC of an instruction reads the opcode. A
                // later one fetches the operand for JMP or LDI.
                w_cycle_nxt = w_cycle_inc;
                if (r_cycle == '0)
                    w_state_nxt = S_FETCH_INST;
                else if (r_opcode == OP_JMP)
                    w_state_nxt = S_JUMP;
                else if (r_opcode == OP_LDI)
                    w_state_nxt = S_SET_REG;
                else
                    w_state_nxt = S_NEXT;
            end
            S_FETCH_INST: begin
                // The branch decision uses the opcode captured on this edge,
                // not the stale latched one.
                if (mem_ready) begin
                    w_latch     = 1'b1;
                    w_opc_eff   = w_opc_in;
                    w_cycle_nxt = w_cycle_inc;
                    if (w_opc_in == OP_HLT)
                        w_state_nxt = S_HALT;
                    else if (w_opc_in == OP_ALU)
                        w_state_nxt = S_ALU_EXEC;
                    else if ((w_opc_in == OP_JMP) || (w_opc_in == OP_LDI))
                        w_state_nxt = S_FETCH_PC;
                    else if (w_opc_in == OP_MOV)
                        w_state_nxt = S_MOV_FETCH;
                    else
                        w_state_nxt = S_NEXT;
                end
            end
            S_ALU_EXEC: begin
                w_state_nxt = S_ALU_STORE;
                w_cycle_nxt = w_cycle_inc;
            end
            S_ALU_STORE, S_JUMP, S_SET_REG, S_MOV_STORE: begin
                w_state_nxt = S_NEXT;
                w_cycle_nxt = w_cycle_inc;
            end
            S_MOV_FETCH: begin
                w_state_nxt = S_MOV_LOAD;
                w_cycle_nxt = w_cycle_inc;
            end
            S_MOV_LOAD: begin
                if (mem_ready) begin
                    w_state_nxt = S_MOV_STORE;
                    w_cycle_nxt = w_cycle_inc;
                end
            end
            S_NEXT: begin
`ifdef SINGLE_STEP_EN
                w_state_nxt = S_STEP_WAIT;
`else
                w_state_nxt = S_FETCH_PC;
                w_cycle_nxt = '0;
`endif
            end
            S_HALT: begin
                if (resume) begin
                    w_state_nxt = S_FETCH_PC;
                    w_cycle_nxt = '0;
                end
            end
            S_STEP_WAIT: begin
`ifdef SINGLE_STEP_EN
                if (step_req) begin
                    w_state_nxt = S_FETCH_PC;
                    w_cycle_nxt = '0;
                end
`else
                // Unreachable without single-step; an upset here just restarts.
                w_state_nxt = S_FETCH_PC;
                w_cycle_nxt = '0;
`endif
            end
            default: begin
                w_state_nxt = S_NEXT;
                w_cycle_nxt = w_cycle_inc;
            end
        endcase

        // The watchdog overrides everything, including a stall. It stays clear
        // of STEP_WAIT, which would otherwise loop through NEXT forever.
        if ((r_cycle == LAST_STEP) && (r_state != S_NEXT) &&
            (r_state != S_HALT) && (r_state != S_STEP_WAIT)) begin
            w_state_nxt = S_NEXT;
            w_cycle_nxt = r_cycle;
            w_latch     = 1'b0;
            w_opc_eff   = r_opcode;
        end

        w_illegal_nxt = (w_state_nxt == S_NEXT) && !opc_legal(w_opc_eff);
    end

    // State, T-state counter, opcode latch and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH_PC;
            r_cycle   <= '0;
            r_opcode  <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cycle   <= w_cycle_nxt;
            r_halted  <= (w_state_nxt == S_HALT);
            r_illegal <= w_illegal_nxt;
            if (w_latch)
                r_opcode <= w_opc_in;
        end
    end

    assign state   = STATE_W'(r_state);
    assign cycle   = r_cycle;
    assign opcode  = r_opcode;
    assign halted  = r_halted;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer. It covers reset, the MOV, ALU
// (stalled), LDI, JMP, HLT/resume and illegal sequences, and reset during a
// MOV_LOAD stall. It works with or without SINGLE_STEP_EN defined.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instruction;
    logic       mem_ready;
    logic       resume;
    logic       step_req;
    logic [7:0] state;
    logic [2:0] cycle;
    logic [3:0] opcode;
    logic       halted;
    logic       illegal;

    int vectors     = 0;
    int miscompares = 0;

    control_sequencer #(
        .INSTR_W  (8),
        .OPC_W    (4),
        .STATE_W  (8),
        .MAX_STEPS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .mem_ready  (mem_ready),
        .resume     (resume),
`ifdef SINGLE_STEP_EN
        .step_req   (step_req),
`endif
        .state      (state),
        .cycle      (cycle),
        .opcode     (opcode),
        .halted     (halted),
        .illegal    (illegal)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input int st, input int cy);
        tick();
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".cycle"}, 32'(cycle), 32'(cy));
    endtask

    // Leave NEXT. With single-step, the instruction parks in STEP_WAIT with the
    // cycle held until step_req is pulsed.
    task automatic finish_instr(input string tag, input int cy);
`ifdef SINGLE_STEP_EN
        step_chk({tag, ".wait"}, 11, cy);
        step_chk({tag, ".wait2"}, 11, cy);
        step_req = 1'b1;
        step_chk({tag, ".stepped"}, 0, 0);
        step_req = 1'b0;
`else
        step_chk({tag, ".boundary"}, 0, 0);
`endif
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 8'h50;
        mem_ready   = 1'b1;
        resume      = 1'b0;
        step_req    = 1'b0;

        // Reset for two edges.
        tick();
        tick();
        chk("rst.state", 32'(state), 0);
        chk("rst.cycle", 32'(cycle), 0);
        chk("rst.opcode", 32'(opcode), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.illegal", 32'(illegal), 0);
        reset = 1'b0;

        // MOV 0x50: 0,1,8,9,10,2,0.
        step_chk("mov.t2", 1, 1);
        step_chk("mov.t3", 8, 2);
        chk("mov.opcode", 32'(opcode), 5);
        step_chk("mov.t4", 9, 3);
        step_chk("mov.t5", 10, 4);
        step_chk("mov.t6", 2, 5);
        chk("mov.illegal", 32'(illegal), 0);
        finish_instr("mov", 5);

        // ALU 0x20 with a three-edge stall in FETCH_INST.
        instruction = 8'h20;
        step_chk("alu.fi", 1, 1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_chk("alu.stall", 1, 1);
            chk("alu.stall.opcode", 32'(opcode), 5);
        end
        mem_ready = 1'b1;
        step_chk("alu.exec", 4, 2);
        chk("alu.opcode", 32'(opcode), 2);
        step_chk("alu.store", 5, 3);
        step_chk("alu.next", 2, 4);
        finish_instr("alu", 4);

        // LDI 0x40: mem_ready is low outside FETCH_INST/MOV_LOAD and ignored there.
        instruction = 8'h40;
        mem_ready   = 1'b0;
        step_chk("ldi.fi", 1, 1);
        mem_ready = 1'b1;
        step_chk("ldi.fpc", 0, 2);
        chk("ldi.opcode", 32'(opcode), 4);
        mem_ready = 1'b0;
        step_chk("ldi.set", 7, 3);
        step_chk("ldi.next", 2, 4);
        mem_ready = 1'b1;
        finish_instr("ldi", 4);

        // JMP 0x30.
        instruction = 8'h30;
        step_chk("jmp.fi", 1, 1);
        step_chk("jmp.fpc", 0, 2);
        step_chk("jmp.jump", 6, 3);
        step_chk("jmp.next", 2, 4);
        finish_instr("jmp", 4);

        // HLT 0x10: sticky for 10 idle edges, then resume.
        instruction = 8'h10;
        step_chk("hlt.fi", 1, 1);
        chk("hlt.halted.pre", 32'(halted), 0);
        step_chk("hlt.enter", 3, 2);
        chk("hlt.halted", 32'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            step_chk("hlt.hold", 3, 2);
            chk("hlt.hold.halted", 32'(halted), 1);
        end
        mem_ready = 1'b1;
        resume    = 1'b1;
        step_chk("hlt.resume", 0, 0);
        chk("hlt.resume.halted", 32'(halted), 0);

        // Illegal 0xF0 with resume held high (ignored outside HALT).
        instruction = 8'hF0;
        step_chk("ill.fi", 1, 1);
        chk("ill.pre", 32'(illegal), 0);
        step_chk("ill.next", 2, 2);
        chk("ill.pulse", 32'(illegal), 1);
        chk("ill.opcode", 32'(opcode), 15);
        resume = 1'b0;
        finish_instr("ill", 2);
        chk("ill.post", 32'(illegal), 0);

        // Reset while stalled in MOV_LOAD.
        instruction = 8'h50;
        step_chk("rmov.fi", 1, 1);
        step_chk("rmov.mf", 8, 2);
        step_chk("rmov.ml", 9, 3);
        mem_ready = 1'b0;
        step_chk("rmov.stall", 9, 3);
        reset = 1'b1;
        step_chk("rmov.reset", 0, 0);
        chk("rmov.opcode", 32'(opcode), 0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        step_chk("rmov.t2", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
